// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states,
// opcode/funct constants, datapath select codes and the decoded-instruction payload.
package mips_mc_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned FUNCT_W = 6;
    localparam int unsigned ST_W    = 4;

    typedef enum logic [ST_W-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MA     = 4'd2,
        S_MR     = 4'd3,
        S_MWB    = 4'd4,
        S_MW     = 4'd5,
        S_EXE    = 4'd6,
        S_RWB    = 4'd7,
        S_BR     = 4'd8,
        S_JMP    = 4'd9
    } state_e;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

    localparam logic [FUNCT_W-1:0] FN_JR   = 6'h08;
    localparam logic [FUNCT_W-1:0] FN_ADDU = 6'h21;
    localparam logic [FUNCT_W-1:0] FN_SUBU = 6'h23;

    localparam logic [1:0] RD_RT = 2'd0;
    localparam logic [1:0] RD_RD = 2'd1;
    localparam logic [1:0] RD_RA = 2'd2;

    localparam logic [1:0] WD_ALU = 2'd0;
    localparam logic [1:0] WD_DM  = 2'd1;
    localparam logic [1:0] WD_PC  = 2'd2;

    localparam logic [1:0] EXT_ZERO = 2'd0;
    localparam logic [1:0] EXT_SIGN = 2'd1;
    localparam logic [1:0] EXT_LUI  = 2'd2;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_OR  = 3'd2;

    localparam logic [1:0] NPC_PC4  = 2'd0;
    localparam logic [1:0] NPC_BR   = 2'd1;
    localparam logic [1:0] NPC_JUMP = 2'd2;
    localparam logic [1:0] NPC_JR   = 2'd3;

    typedef enum logic [2:0] {
        CLS_ILL    = 3'd0,
        CLS_MEM_LD = 3'd1,
        CLS_MEM_ST = 3'd2,
        CLS_RTYPE  = 3'd3,
        CLS_ITYPE  = 3'd4,
        CLS_BR     = 3'd5,
        CLS_JUMP   = 3'd6
    } cls_e;

    // Decoded instruction: class plus the EXE/JMP selects it implies
    typedef struct packed {
        cls_e       cls;
        logic [2:0] alu_op;
        logic       alu_srcb;
        logic [1:0] ext_op;
        logic [1:0] jmp_npc;
        logic       link;
    } dec_t;

endpackage

// File: rtl/mips_mc_dec.sv
// Combinational opcode/funct decoder: maps the instruction register fields
// to an instruction class and the ALU/extender/NPC selects for EXE and JMP.
module mips_mc_dec
    import mips_mc_pkg::*;
(
    input  logic [OP_W-1:0]    op_i,
    input  logic [FUNCT_W-1:0] funct_i,
    output dec_t               dec_o_c
);

    always_comb begin
        dec_o_c          = '0;
        dec_o_c.cls      = CLS_ILL;
        dec_o_c.alu_op   = ALU_ADD;
        dec_o_c.alu_srcb = 1'b0;
        dec_o_c.ext_op   = EXT_ZERO;
        dec_o_c.jmp_npc  = NPC_JUMP;
        dec_o_c.link     = 1'b0;
        case (op_i)
            OP_LW:  dec_o_c.cls = CLS_MEM_LD;
            OP_SW:  dec_o_c.cls = CLS_MEM_ST;
            OP_RTYPE: begin
                case (funct_i)
                    FN_ADDU: begin
                        dec_o_c.cls    = CLS_RTYPE;
                        dec_o_c.alu_op = ALU_ADD;
                    end
                    FN_SUBU: begin
                        dec_o_c.cls    = CLS_RTYPE;
                        dec_o_c.alu_op = ALU_SUB;
                    end
                    FN_JR: begin
                        dec_o_c.cls     = CLS_JUMP;
                        dec_o_c.jmp_npc = NPC_JR;
                    end
                    default: dec_o_c.cls = CLS_ILL;
                endcase
            end
            OP_ORI: begin
                dec_o_c.cls      = CLS_ITYPE;
                dec_o_c.alu_op   = ALU_OR;
                dec_o_c.alu_srcb = 1'b1;
                dec_o_c.ext_op   = EXT_ZERO;
            end
            // lui relies on rs=$0, so add yields imm<<16
            OP_LUI: begin
                dec_o_c.cls      = CLS_ITYPE;
                dec_o_c.alu_op   = ALU_ADD;
                dec_o_c.alu_srcb = 1'b1;
                dec_o_c.ext_op   = EXT_LUI;
            end
            OP_BEQ: dec_o_c.cls = CLS_BR;
            OP_J: begin
                dec_o_c.cls     = CLS_JUMP;
                dec_o_c.jmp_npc = NPC_JUMP;
            end
            OP_JAL: begin
                dec_o_c.cls     = CLS_JUMP;
                dec_o_c.jmp_npc = NPC_JUMP;
                dec_o_c.link    = 1'b1;
            end
            default: dec_o_c.cls = CLS_ILL;
        endcase
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control FSM (IF/ID/EX/MEM/WB) driving datapath enables and selects.
// Optional MIPS_MC_MEM_WAIT_EN: MR/MW stall until dm_ready.
module mips_mc_ctrl
    import mips_mc_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [OP_W-1:0]    op,
    input  logic [FUNCT_W-1:0] funct,
    input  logic               zero,
    input  logic               dm_ready,
    output logic               pc_wr,
    output logic               ir_wr,
    output logic               gpr_wr,
    output logic               dm_wr,
    output logic [1:0]         reg_dst,
    output logic [1:0]         wd_sel,
    output logic               alu_srcb,
    output logic [1:0]         ext_op,
    output logic [2:0]         alu_op,
    output logic [1:0]         npc_op,
    output logic               illegal,
    output logic [ST_W-1:0]    state
);

    state_e state_q;
    state_e state_d;
    dec_t   dec;
    logic   mem_done;

    mips_mc_dec u_dec (
        .op_i    (op),
        .funct_i (funct),
        .dec_o_c (dec)
    );

`ifdef MIPS_MC_MEM_WAIT_EN
    assign mem_done = dm_ready;
`else
    logic unused_dm_ready;
    assign unused_dm_ready = dm_ready;
    assign mem_done        = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = ST_W'(state_q);

    // Next state and Moore outputs; reset forces everything idle in the same cycle
    always_comb begin
        state_d  = state_q;
        pc_wr    = 1'b0;
        ir_wr    = 1'b0;
        gpr_wr   = 1'b0;
        dm_wr    = 1'b0;
        reg_dst  = RD_RT;
        wd_sel   = WD_ALU;
        alu_srcb = 1'b0;
        ext_op   = EXT_ZERO;
        alu_op   = ALU_ADD;
        npc_op   = NPC_PC4;
        illegal  = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    pc_wr   = 1'b1;
                    ir_wr   = 1'b1;
                    npc_op  = NPC_PC4;
                    state_d = S_DECODE;
                end
                S_DECODE: begin
                    case (dec.cls)
                        CLS_MEM_LD, CLS_MEM_ST: state_d = S_MA;
                        CLS_RTYPE, CLS_ITYPE:   state_d = S_EXE;
                        CLS_BR:                 state_d = S_BR;
                        CLS_JUMP:               state_d = S_JMP;
                        default: begin
                            illegal = 1'b1;
                            state_d = S_FETCH;
                        end
                    endcase
                end
                S_MA: begin
                    alu_srcb = 1'b1;
                    ext_op   = EXT_SIGN;
                    alu_op   = ALU_ADD;
                    state_d  = (dec.cls == CLS_MEM_ST) ? S_MW : S_MR;
                end
                // Address path held stable for the whole memory access
                S_MR: begin
                    alu_srcb = 1'b1;
                    ext_op   = EXT_SIGN;
                    alu_op   = ALU_ADD;
                    if (mem_done) begin
                        state_d = S_MWB;
                    end
                end
                S_MWB: begin
                    alu_srcb = 1'b1;
                    ext_op   = EXT_SIGN;
                    alu_op   = ALU_ADD;
                    gpr_wr   = 1'b1;
                    reg_dst  = RD_RT;
                    wd_sel   = WD_DM;
                    state_d  = S_FETCH;
                end
                S_MW: begin
                    alu_srcb = 1'b1;
                    ext_op   = EXT_SIGN;
                    alu_op   = ALU_ADD;
                    dm_wr    = 1'b1;
                    if (mem_done) begin
                        state_d = S_FETCH;
                    end
                end
                S_EXE: begin
                    alu_srcb = dec.alu_srcb;
                    ext_op   = dec.ext_op;
                    alu_op   = dec.alu_op;
                    state_d  = S_RWB;
                end
                // ALU result is written straight from the ALU, so keep its controls
                S_RWB: begin
                    alu_srcb = dec.alu_srcb;
                    ext_op   = dec.ext_op;
                    alu_op   = dec.alu_op;
                    gpr_wr   = 1'b1;
                    wd_sel   = WD_ALU;
                    reg_dst  = (dec.cls == CLS_RTYPE) ? RD_RD : RD_RT;
                    state_d  = S_FETCH;
                end
                S_BR: begin
                    alu_op   = ALU_SUB;
                    alu_srcb = 1'b0;
                    npc_op   = NPC_BR;
                    pc_wr    = zero;
                    state_d  = S_FETCH;
                end
                S_JMP: begin
                    pc_wr   = 1'b1;
                    npc_op  = dec.jmp_npc;
                    if (dec.link) begin
                        gpr_wr  = 1'b1;
                        reg_dst = RD_RA;
                        wd_sel  = WD_PC;
                    end
                    state_d = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Scoreboard bench for mips_mc_ctrl: the driver queues per-cycle expected
// outputs, a negedge monitor pops and compares them under a care mask.
module tb_mips_mc_ctrl;
    import mips_mc_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       dm_ready;
    logic       pc_wr, ir_wr, gpr_wr, dm_wr, alu_srcb, illegal;
    logic [1:0] reg_dst, wd_sel, ext_op, npc_op;
    logic [2:0] alu_op;
    logic [3:0] state;

    always #5 clk = ~clk;

    mips_mc_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .op       (op),
        .funct    (funct),
        .zero     (zero),
        .dm_ready (dm_ready),
        .pc_wr    (pc_wr),
        .ir_wr    (ir_wr),
        .gpr_wr   (gpr_wr),
        .dm_wr    (dm_wr),
        .reg_dst  (reg_dst),
        .wd_sel   (wd_sel),
        .alu_srcb (alu_srcb),
        .ext_op   (ext_op),
        .alu_op   (alu_op),
        .npc_op   (npc_op),
        .illegal  (illegal),
        .state    (state)
    );

    // {state, pc_wr, ir_wr, gpr_wr, dm_wr, illegal, reg_dst, wd_sel, alu_srcb, ext_op, alu_op, npc_op}
    typedef logic [20:0] vec_t;
    localparam vec_t M_ALL  = 21'h1FFFFF;
    localparam vec_t M_BASE = 21'h1FF000;
    localparam vec_t M_RD   = 21'h000C00;
    localparam vec_t M_WS   = 21'h000300;
    localparam vec_t M_SB   = 21'h000080;
    localparam vec_t M_EX   = 21'h000060;
    localparam vec_t M_AO   = 21'h00001C;
    localparam vec_t M_NP   = 21'h000003;

`ifdef MIPS_MC_MEM_WAIT_EN
    localparam bit DMR_IDLE = 1'b1;
`else
    localparam bit DMR_IDLE = 1'b0;
`endif

    vec_t  exp_q[$];
    vec_t  msk_q[$];
    string nam_q[$];
    int    checks = 0;
    int    errors = 0;
    vec_t  act;

    assign act = {state, pc_wr, ir_wr, gpr_wr, dm_wr, illegal, reg_dst, wd_sel,
                  alu_srcb, ext_op, alu_op, npc_op};

    function automatic vec_t ev(int st, bit pc, bit ir, bit gw, bit dw, bit ill,
                                int rd, int ws, bit sb, int ex, int ao, int np);
        return {4'(st), pc, ir, gw, dw, ill, 2'(rd), 2'(ws), sb, 2'(ex), 3'(ao), 2'(np)};
    endfunction

    // Monitor: one comparison per cycle whenever an expectation is pending
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            vec_t  e;
            vec_t  m;
            string n;
            e = exp_q.pop_front();
            m = msk_q.pop_front();
            n = nam_q.pop_front();
            checks++;
            if ((act & m) !== (e & m)) begin
                errors++;
                $display("FAIL %s: got %h want %h (mask %h)", n, act & m, e & m, m);
            end
        end
    end

    task automatic step(input vec_t e, input vec_t m, input string n);
        exp_q.push_back(e);
        msk_q.push_back(m);
        nam_q.push_back(n);
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic [5:0] o, input logic [5:0] f, input string n);
        op    = o;
        funct = f;
        step(ev(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), M_BASE | M_NP, {n, ":F"});
    endtask

    task automatic do_decode(input bit ill, input string n);
        step(ev(1, 0, 0, 0, 0, ill, 0, 0, 0, 0, 0, 0), M_BASE, {n, ":D"});
    endtask

    task automatic do_alu(input logic [5:0] o, input logic [5:0] f, input int ao,
                          input bit sb, input int ex, input vec_t exm, input int rd,
                          input string n);
        do_fetch(o, f, n);
        do_decode(1'b0, n);
        step(ev(6, 0, 0, 0, 0, 0, 0, 0, sb, ex, ao, 0), M_BASE | M_AO | M_SB | exm, {n, ":EXE"});
        step(ev(7, 0, 0, 1, 0, 0, rd, 0, 0, 0, 0, 0), M_BASE | M_RD | M_WS, {n, ":RWB"});
    endtask

    task automatic do_ma(input string n);
        step(ev(2, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0), M_BASE | M_SB | M_EX | M_AO, {n, ":MA"});
    endtask

    task automatic do_jmp(input logic [5:0] o, input logic [5:0] f, input int np,
                          input bit link, input string n);
        do_fetch(o, f, n);
        do_decode(1'b0, n);
        if (link)
            step(ev(9, 1, 0, 1, 0, 0, 2, 2, 0, 0, 0, np), M_BASE | M_RD | M_WS | M_NP, {n, ":JMP"});
        else
            step(ev(9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, np), M_BASE | M_NP, {n, ":JMP"});
    endtask

    task automatic do_beq(input bit z, input string n);
        do_fetch(OP_BEQ, 6'h00, n);
        do_decode(1'b0, n);
        zero = z;
        step(ev(8, z, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), M_BASE | M_SB | M_AO | M_NP, {n, ":BR"});
        zero = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        op       = 6'h00;
        funct    = 6'h00;
        zero     = 1'b0;
        dm_ready = DMR_IDLE;
        @(posedge clk);
        #1;
        step(ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), M_ALL, "rst_c0");
        step(ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), M_ALL, "rst_c1");
        rst = 1'b0;

        do_alu(OP_RTYPE, FN_ADDU, 0, 1'b0, 0, '0,   1, "addu");
        do_alu(OP_RTYPE, FN_SUBU, 1, 1'b0, 0, '0,   1, "subu");
        do_alu(OP_ORI,   6'h15,   2, 1'b1, 0, M_EX, 0, "ori");
        do_alu(OP_LUI,   6'h00,   0, 1'b1, 2, M_EX, 0, "lui");

        do_fetch(OP_LW, 6'h00, "lw");
        do_decode(1'b0, "lw");
        do_ma("lw");
        step(ev(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), M_BASE, "lw:MR");
        step(ev(4, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0), M_BASE | M_RD | M_WS, "lw:MWB");

        do_fetch(OP_SW, 6'h00, "sw");
        do_decode(1'b0, "sw");
        do_ma("sw");
        step(ev(5, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), M_BASE, "sw:MW");

        do_beq(1'b1, "beq_t");
        do_beq(1'b0, "beq_nt");
        do_jmp(OP_J,     6'h00, 2, 1'b0, "j");
        do_jmp(OP_JAL,   6'h00, 2, 1'b1, "jal");
        do_jmp(OP_RTYPE, FN_JR, 3, 1'b0, "jr");

        do_fetch(6'h3F, 6'h00, "ill3f");
        do_decode(1'b1, "ill3f");
        do_fetch(OP_RTYPE, 6'h20, "illadd");
        do_decode(1'b1, "illadd");

        // Reset while in MW: write suppressed at once, FETCH next
        do_fetch(OP_SW, 6'h00, "sw_rst");
        do_decode(1'b0, "sw_rst");
        do_ma("sw_rst");
        rst = 1'b1;
        step(ev(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), M_ALL, "sw_rst:MW");
        rst = 1'b0;

`ifdef MIPS_MC_MEM_WAIT_EN
        do_fetch(OP_LW, 6'h00, "lw_wait");
        do_decode(1'b0, "lw_wait");
        do_ma("lw_wait");
        dm_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            step(ev(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), M_BASE, "lw_wait:MRw");
        dm_ready = 1'b1;
        step(ev(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), M_BASE, "lw_wait:MR");
        step(ev(4, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0), M_BASE | M_RD | M_WS, "lw_wait:MWB");

        do_fetch(OP_SW, 6'h00, "sw_wait");
        do_decode(1'b0, "sw_wait");
        do_ma("sw_wait");
        dm_ready = 1'b0;
        step(ev(5, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), M_BASE, "sw_wait:MWw");
        dm_ready = 1'b1;
        step(ev(5, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), M_BASE, "sw_wait:MW");
`endif

        do_fetch(OP_RTYPE, 6'h00, "end");

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: pending %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run still active at %0t want finished", $time);
        $fatal(1, "timeout");
    end

endmodule
